fifo_read_ctrl: RTL and testbench

- Read-side controller for the 16-bit Sync_FIFO: pops words using the FIFO's read_en/empty interface and forwards them downstream on a valid/ready stream.
- Hides the FIFO's one-cycle read latency with a 2-entry output buffer, so a continuously-ready sink receives one word per clock.
- Sits between Sync_FIFO and any consumer block; the counterpart of the push-side producer logic.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_skid_buf2.sv | 61 ++++++
 rtl/fifo_read_ctrl.sv | 116 +++++++++++
 tb/tb_fifo_read_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the Sync_FIFO read-side controller: word width,
// FIFO read latency and the read-controller state encoding.
package fifo_pkg;

  localparam int FIFO_DATA_W     = 16;
  localparam int FIFO_RD_LATENCY = 1;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry ordered output buffer: entry 0 is always the head; a pop shifts
// entry 1 forward, and a simultaneous push/pop keeps the count and the order.
module fifo_skid_buf2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clear,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] entry0;
  logic [DATA_W-1:0] entry1;
  logic [1:0]        cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      entry0 <= '0;
      entry1 <= '0;
      cnt_q  <= 2'd0;
    end else if (clear) begin
      cnt_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            entry0 <= push_data;
            cnt_q  <= 2'd1;
          end else if (cnt_q == 2'd1) begin
            entry1 <= push_data;
            cnt_q  <= 2'd2;
          end
        end
        2'b01: begin
          entry0 <= entry1;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // With one entry the incoming word becomes the new head; with two
          // it queues behind the shifted-forward second entry.
          if (cnt_q == 2'd2) begin
            entry0 <= entry1;
            entry1 <= push_data;
          end else begin
            entry0 <= push_data;
            cnt_q  <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign count     = cnt_q;
  assign head_data = entry0;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for Sync_FIFO: credit-based pops into a 2-entry skid
// buffer feeding a valid/ready stream. Optional checksum: FIFO_READ_CHECKSUM_EN.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   RUN   | normal operation, reads issued while credits are free
//   DRAIN | one-cycle guard after a flush that caught a word in flight
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_rd_en_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  word_cnt_o
`ifdef FIFO_READ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] csum_o
`endif
);

  localparam logic [1:0] CREDITS = 2'(1 + FIFO_RD_LATENCY);

  rd_state_t         state_q, state_d;
  logic              inflight_q;
  logic [1:0]        buf_cnt;
  logic [1:0]        credit_used;
  logic              accept;
  logic              room;
  logic              push;
  logic              clear;
  logic [CNT_W-1:0]  word_cnt_q;

  // A flush wins over a same-cycle handshake, so that transfer is not counted.
  assign accept      = m_valid_o & m_ready_i & ~flush_i;
  assign credit_used = buf_cnt + {1'b0, inflight_q};
  assign room        = (credit_used - {1'b0, accept}) < CREDITS;

  always_comb begin
    state_d      = state_q;
    fifo_rd_en_o = 1'b0;
    push         = 1'b0;
    clear        = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_i) begin
          clear = 1'b1;
          if (inflight_q) state_d = DRAIN;
        end else begin
          fifo_rd_en_o = ~fifo_empty_i & room;
          push         = inflight_q;
        end
      end
      DRAIN: begin
        clear   = flush_i;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= RUN;
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en_o;
      if (accept) word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  fifo_skid_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push      (push),
    .push_data (fifo_data_i),
    .pop       (accept),
    .clear     (clear),
    .count     (buf_cnt),
    .head_data (m_data_o)
  );

  assign m_valid_o  = (buf_cnt != 2'd0);
  assign busy_o     = (state_q != RUN) | (buf_cnt != 2'd0) | inflight_q;
  assign word_cnt_o = word_cnt_q;

`ifdef FIFO_READ_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      csum_q <= '0;
    end else if (flush_i) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= csum_q ^ m_data_o;
    end
  end

  assign csum_o = csum_q;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a behavioural Sync_FIFO model and a
// stream monitor; checksum checks are compiled in with FIFO_READ_CHECKSUM_EN.
module tb_fifo_read_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        fifo_empty_i;
  logic [15:0] fifo_data_i;
  logic        fifo_rd_en_o;
  logic [15:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic [15:0] word_cnt_o;
`ifdef FIFO_READ_CHECKSUM_EN
  logic [15:0] csum_o;
`endif

  fifo_read_ctrl dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .word_cnt_o   (word_cnt_o)
`ifdef FIFO_READ_CHECKSUM_EN
    ,
    .csum_o       (csum_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Sync_FIFO model: one-cycle read latency, reset empties it.
  logic [15:0] mem [0:127];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int total_pops = 0;
  int underflow = 0;

  assign fifo_empty_i = (rd_ptr == wr_ptr);

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr      <= wr_ptr;
      fifo_data_i <= '0;
    end else if (fifo_rd_en_o) begin
      if (rd_ptr == wr_ptr) begin
        underflow <= underflow + 1;
      end else begin
        fifo_data_i <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + 1;
        total_pops  <= total_pops + 1;
      end
    end
  end

  // Stream monitor: logs accepted words and checks hold-while-stalled.
  logic [15:0] rx [0:127];
  int          rx_total = 0;
  int          stall_err = 0;
  logic        stall_pend = 1'b0;
  logic [15:0] held = '0;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_pend <= 1'b0;
    end else begin
      if (stall_pend && (!m_valid_o || m_data_o !== held)) stall_err <= stall_err + 1;
      if (m_valid_o && m_ready_i && !flush_i) begin
        rx[rx_total] <= m_data_o;
        rx_total     <= rx_total + 1;
      end
      stall_pend <= m_valid_o && !m_ready_i && !flush_i;
      held       <= m_data_o;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check_order(input string tag, input int rxb, input int memb, input int n);
    int errs = 0;
    for (int i = 0; i < n; i++)
      if (rx[rxb + i] !== mem[memb + i]) errs++;
    check(tag, errs, 0);
  endtask

  initial begin
    int base_w, base_rx, base_pops;
    int first, last, nvalid, max_out, cur_out, rd_seen;
    logic [3:0] pat;

    // Reset values
    step(2);
    check("rst_valid", m_valid_o, 1'b0);
    check("rst_data", m_data_o, 16'h0000);
    check("rst_busy", busy_o, 1'b0);
    check("rst_cnt", word_cnt_o, 16'd0);
    check("rst_rd_en", fifo_rd_en_o, 1'b0);
    rst_n_i = 1'b1;
    step(2);

    // Streaming: 25 words, sink always ready
    base_w = wr_ptr; base_rx = rx_total;
    for (int i = 0; i < 25; i++) load(16'($urandom));
    m_ready_i = 1'b1;
    #1 check("stream_first_rd", fifo_rd_en_o, 1'b1);
    first = -1; last = -1; nvalid = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_i);
      if (m_valid_o) begin
        if (first < 0) first = c;
        last = c;
        nvalid++;
      end
    end
    check("stream_first_valid", first, 2);
    check("stream_contig", last - first + 1, 25);
    check("stream_nvalid", nvalid, 25);
    check("stream_rx", rx_total - base_rx, 25);
    check_order("stream_order", base_rx, base_w, 25);
    check("stream_cnt", word_cnt_o, 16'd25);
    check("stream_underflow", underflow, 0);

    // Backpressure: ready pattern 1,0,0,1
    base_w = wr_ptr; base_rx = rx_total; base_pops = total_pops;
    for (int i = 0; i < 8; i++) load(16'hA500 + 16'(i));
    pat = 4'b1001; max_out = 0;
    for (int c = 0; c < 40; c++) begin
      m_ready_i = pat[c % 4];
      @(negedge clk_i);
      cur_out = (total_pops - base_pops) - (rx_total - base_rx);
      if (cur_out > max_out) max_out = cur_out;
    end
    m_ready_i = 1'b1;
    check("bp_rx", rx_total - base_rx, 8);
    check_order("bp_order", base_rx, base_w, 8);
    check("bp_cnt", word_cnt_o, 16'd33);
    check("bp_stable", stall_err, 0);
    check("bp_max_outstanding", max_out <= 2, 1'b1);

    // Empty: 3 words then FIFO runs dry
    base_w = wr_ptr; base_rx = rx_total;
    for (int i = 0; i < 3; i++) load(16'h3C00 + 16'(i));
    step(15);
    check("empty_rx", rx_total - base_rx, 3);
    check_order("empty_order", base_rx, base_w, 3);
    check("empty_valid", m_valid_o, 1'b0);
    check("empty_rd_en", fifo_rd_en_o, 1'b0);
    check("empty_busy", busy_o, 1'b0);
    check("empty_cnt", word_cnt_o, 16'd36);
    check("empty_underflow", underflow, 0);

    // Flush with one buffered word and one in flight
    m_ready_i = 1'b0;
    base_w = wr_ptr;
    for (int i = 0; i < 4; i++) load(16'h7700 + 16'(i));
    step(2);
    check("fl_pre_valid", m_valid_o, 1'b1);
    check("fl_pre_rd_en", fifo_rd_en_o, 1'b0);
    check("fl_pre_busy", busy_o, 1'b1);
    flush_i = 1'b1;
    #1 check("fl_cycle_rd_en", fifo_rd_en_o, 1'b0);
    base_rx = rx_total;
    step(1);
    flush_i = 1'b0;
    #1;
    check("fl_drain_valid", m_valid_o, 1'b0);
    check("fl_drain_busy", busy_o, 1'b1);
    check("fl_drain_rd_en", fifo_rd_en_o, 1'b0);
    step(1);
    check("fl_run_busy", busy_o, 1'b0);
    check("fl_run_rd_en", fifo_rd_en_o, 1'b1);
    m_ready_i = 1'b1;
    step(10);
    check("fl_rx", rx_total - base_rx, 2);
    check_order("fl_order", base_rx, base_w + 2, 2);
    check("fl_cnt", word_cnt_o, 16'd38);

    // Flush held high keeps the block idle
    base_w = wr_ptr; base_rx = rx_total;
    load(16'h5A5A); load(16'hC3C3);
    flush_i = 1'b1; rd_seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1 if (fifo_rd_en_o) rd_seen++;
      @(negedge clk_i);
    end
    check("hold_rd_seen", rd_seen, 0);
    check("hold_cnt", word_cnt_o, 16'd38);
    flush_i = 1'b0;
    step(8);
    check("hold_rx", rx_total - base_rx, 2);
    check_order("hold_order", base_rx, base_w, 2);
    check("hold_cnt2", word_cnt_o, 16'd40);

    // Reset mid-stream
    for (int i = 0; i < 10; i++) load(16'h9000 + 16'(i));
    step(5);
    #2 rst_n_i = 1'b0;
    #1;
    check("mrst_valid", m_valid_o, 1'b0);
    check("mrst_data", m_data_o, 16'h0000);
    check("mrst_busy", busy_o, 1'b0);
    check("mrst_cnt", word_cnt_o, 16'd0);
    check("mrst_rd_en", fifo_rd_en_o, 1'b0);
    step(1);
    rst_n_i = 1'b1;
    step(1);
    base_w = wr_ptr; base_rx = rx_total;
    for (int i = 0; i < 3; i++) load(16'h4400 + 16'(i));
    step(10);
    check("mrst_rx", rx_total - base_rx, 3);
    check_order("mrst_order", base_rx, base_w, 3);
    check("mrst_cnt_after", word_cnt_o, 16'd3);

`ifdef FIFO_READ_CHECKSUM_EN
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    step(2);
    check("csum_clear0", csum_o, 16'h0000);
    load(16'h1234); load(16'h00FF);
    step(8);
    check("csum_value", csum_o, 16'h12CB);
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    #1 check("csum_flush", csum_o, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
